// File: rtl/huffman_frame_sched.sv
// Frame scheduler for the six-symbol Huffman encoder: re-arms the core, streams one frame of
// pixels into it and returns the captured CNT/M/HC results. Define HUF_SCHED_WDOG_EN for the watchdog.
module huffman_frame_sched #(
    parameter int unsigned FRAME_LEN    = 100,
    parameter int unsigned REARM_CYCLES = 2,
    parameter int unsigned WDOG_CYCLES  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        enc_reset,
    output logic        enc_gray_valid,
    output logic [7:0]  enc_gray_data,
    input  logic        enc_cnt_valid,
    input  logic        enc_code_valid,
    input  logic [47:0] enc_cnt,
    input  logic [47:0] enc_m,
    input  logic [47:0] enc_hc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_cnt,
    output logic [47:0] res_m,
    output logic [47:0] res_hc,
    output logic        err_bad_pix,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StRearm,
        StFeed,
        StWaitCnt,
        StWaitCode,
        StHold
    } state_e;

    localparam logic [7:0] FrameLast = 8'(FRAME_LEN - 1);
    localparam logic [3:0] RearmLast = 4'(REARM_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  rearm_cnt_q, rearm_cnt_d;
    logic [7:0]  feed_cnt_q, feed_cnt_d;
    logic        gray_valid_q, gray_valid_d;
    logic [7:0]  gray_data_q, gray_data_d;
    logic [47:0] res_cnt_q, res_cnt_d;
    logic [47:0] res_m_q, res_m_d;
    logic [47:0] res_hc_q, res_hc_d;
    logic        res_valid_q, res_valid_d;
    logic        busy_q, busy_d;
    logic        pix_ready_q, pix_ready_d;
    logic        enc_reset_q, enc_reset_d;
    logic        err_bad_pix_q, err_bad_pix_d;
    logic        start_accept;
    logic        wdog_hit;
    logic        timeout_fire;
    logic        pix_ok;

    assign pix_ok = (pix_data >= 8'd1) && (pix_data <= 8'd6);

    always_comb begin
        state_d       = state_q;
        rearm_cnt_d   = rearm_cnt_q;
        feed_cnt_d    = feed_cnt_q;
        gray_valid_d  = 1'b0;
        gray_data_d   = gray_data_q;
        res_cnt_d     = res_cnt_q;
        res_m_d       = res_m_q;
        res_hc_d      = res_hc_q;
        err_bad_pix_d = err_bad_pix_q;
        start_accept  = 1'b0;
        timeout_fire  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = StRearm;
                    rearm_cnt_d  = '0;
                end
            end
            StRearm: begin
                feed_cnt_d = '0;
                if (rearm_cnt_q == RearmLast) begin
                    state_d = StFeed;
                end else begin
                    rearm_cnt_d = rearm_cnt_q + 4'd1;
                end
            end
            StFeed: begin
                if (pix_valid && pix_ready_q) begin
                    if (pix_ok) begin
                        gray_valid_d = 1'b1;
                        gray_data_d  = pix_data;
                        feed_cnt_d   = feed_cnt_q + 8'd1;
                        if (feed_cnt_q == FrameLast) begin
                            state_d = StWaitCnt;
                        end
                    end else begin
                        err_bad_pix_d = 1'b1;
                    end
                end
            end
            StWaitCnt: begin
                if (enc_cnt_valid) begin
                    res_cnt_d = enc_cnt;
                    state_d   = StWaitCode;
                end else if (wdog_hit) begin
                    timeout_fire = 1'b1;
                    state_d      = StIdle;
                end
            end
            StWaitCode: begin
                if (enc_code_valid) begin
                    res_m_d  = enc_m;
                    res_hc_d = enc_hc;
                    state_d  = StHold;
                end else if (wdog_hit) begin
                    timeout_fire = 1'b1;
                    state_d      = StIdle;
                end
            end
            StHold: begin
                if (res_ready) begin
                    if (start) begin
                        start_accept = 1'b1;
                        state_d      = StRearm;
                        rearm_cnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_accept) begin
            err_bad_pix_d = 1'b0;
        end

        // Outputs are registered copies of the next state, so they switch with the state itself.
        enc_reset_d = (state_d == StRearm);
        pix_ready_d = (state_d == StFeed);
        busy_d      = (state_d != StIdle);
        res_valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rearm_cnt_q   <= '0;
            feed_cnt_q    <= '0;
            gray_valid_q  <= 1'b0;
            gray_data_q   <= '0;
            res_cnt_q     <= '0;
            res_m_q       <= '0;
            res_hc_q      <= '0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            pix_ready_q   <= 1'b0;
            enc_reset_q   <= 1'b1;
            err_bad_pix_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rearm_cnt_q   <= rearm_cnt_d;
            feed_cnt_q    <= feed_cnt_d;
            gray_valid_q  <= gray_valid_d;
            gray_data_q   <= gray_data_d;
            res_cnt_q     <= res_cnt_d;
            res_m_q       <= res_m_d;
            res_hc_q      <= res_hc_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            pix_ready_q   <= pix_ready_d;
            enc_reset_q   <= enc_reset_d;
            err_bad_pix_q <= err_bad_pix_d;
        end
    end

`ifdef HUF_SCHED_WDOG_EN
    localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_q, wdog_d;
    logic        err_timeout_q, err_timeout_d;
    logic        waiting;

    // One budget covers both wait states; it is only cleared while re-arming.
    assign waiting  = (state_q == StWaitCnt) || (state_q == StWaitCode);
    assign wdog_hit = waiting && (wdog_q == WdogLast);

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StRearm) begin
            wdog_d = '0;
        end else if (waiting) begin
            wdog_d = wdog_q + 16'd1;
        end
        err_timeout_d = err_timeout_q;
        if (start_accept) begin
            err_timeout_d = 1'b0;
        end else if (timeout_fire) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_wdog;
    assign unused_wdog = timeout_fire ^ (^WDOG_CYCLES);
    assign wdog_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy           = busy_q;
    assign pix_ready      = pix_ready_q;
    assign enc_reset      = enc_reset_q;
    assign enc_gray_valid = gray_valid_q;
    assign enc_gray_data  = gray_data_q;
    assign res_valid      = res_valid_q;
    assign res_cnt        = res_cnt_q;
    assign res_m          = res_m_q;
    assign res_hc         = res_hc_q;
    assign err_bad_pix    = err_bad_pix_q;

endmodule

// File: tb/tb_huffman_frame_sched.sv
// Scoreboard bench for huffman_frame_sched with a simple encoder-core model.
module tb_huffman_frame_sched;

    localparam logic [47:0] EXP_CNT = 48'h0f0f0f0f1414;
    localparam logic [47:0] M_PAT   = 48'h060504030201;
    localparam logic [47:0] HC_PAT  = 48'h3e1e0e060200;
    localparam logic [47:0] GARB    = 48'hdeadbeefcafe;
    localparam int          WDOG    = 255;

    logic        clk = 1'b0;
    logic        reset, start, busy, pix_valid, pix_ready, enc_reset;
    logic [7:0]  pix_data, enc_gray_data;
    logic        enc_gray_valid, enc_cnt_valid, enc_code_valid;
    logic [47:0] enc_cnt, enc_m, enc_hc, res_cnt, res_m, res_hc;
    logic        res_valid, res_ready, err_bad_pix, err_timeout;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int res_seen = 0;
    int res_target = 0;
    int core_delay = 0;
    logic [7:0]   exp_pix[$];
    logic [143:0] exp_res[$];

    logic [7:0] cm_cnt[6];
    int cm_tot, cm_phase, cm_dly, cm_idx;

    always #5 clk = ~clk;

    huffman_frame_sched dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .enc_reset      (enc_reset),
        .enc_gray_valid (enc_gray_valid),
        .enc_gray_data  (enc_gray_data),
        .enc_cnt_valid  (enc_cnt_valid),
        .enc_code_valid (enc_code_valid),
        .enc_cnt        (enc_cnt),
        .enc_m          (enc_m),
        .enc_hc         (enc_hc),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_cnt        (res_cnt),
        .res_m          (res_m),
        .res_hc         (res_hc),
        .err_bad_pix    (err_bad_pix),
        .err_timeout    (err_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sym(input int i);
        if (i < 20) return 8'd1;
        if (i < 40) return 8'd2;
        if (i < 55) return 8'd3;
        if (i < 70) return 8'd4;
        if (i < 85) return 8'd5;
        return 8'd6;
    endfunction

    // Pixel monitor: every strobe must match the next accepted legal pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (enc_gray_valid) begin
                strobes++;
                if (exp_pix.size() == 0) chk("pix_unexpected", 64'(1), 64'(0));
                else chk("pix_data", 64'(enc_gray_data), 64'(exp_pix.pop_front()));
            end
        end
    end

    // Result monitor: compares on each res handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                res_seen++;
                if (exp_res.size() == 0) begin
                    chk("res_unexpected", 64'(1), 64'(0));
                end else begin
                    logic [143:0] e;
                    e = exp_res.pop_front();
                    chk("res_cnt", 64'(res_cnt), 64'(e[143:96]));
                    chk("res_m", 64'(res_m), 64'(e[95:48]));
                    chk("res_hc", 64'(res_hc), 64'(e[47:0]));
                end
            end
        end
    end

    // Encoder core model: counts strobes, reports CNT after core_delay cycles, then M/HC.
    initial begin
        enc_cnt_valid = 1'b0; enc_code_valid = 1'b0;
        enc_cnt = GARB; enc_m = GARB; enc_hc = GARB;
        cm_tot = 0; cm_phase = 0; cm_dly = 0; cm_idx = 0;
        forever begin
            @(posedge clk); #1;
            enc_cnt_valid = 1'b0; enc_code_valid = 1'b0;
            enc_cnt = GARB; enc_m = GARB; enc_hc = GARB;
            if (enc_reset) begin
                for (int i = 0; i < 6; i++) cm_cnt[i] = 8'd0;
                cm_tot = 0;
                cm_phase = 0;
            end else begin
                if (enc_gray_valid && enc_gray_data >= 8'd1 && enc_gray_data <= 8'd6) begin
                    cm_idx = int'(enc_gray_data) - 1;
                    cm_cnt[cm_idx] = cm_cnt[cm_idx] + 8'd1;
                    cm_tot++;
                    if (cm_tot == 100) begin
                        cm_phase = 1;
                        cm_dly = core_delay;
                    end
                end
                if (cm_phase == 1) begin
                    if (cm_dly == 0) begin
                        enc_cnt_valid = 1'b1;
                        enc_cnt = {cm_cnt[5], cm_cnt[4], cm_cnt[3], cm_cnt[2], cm_cnt[1], cm_cnt[0]};
                        cm_phase = 2;
                    end else begin
                        cm_dly--;
                    end
                end else if (cm_phase == 2) begin
                    enc_code_valid = 1'b1;
                    enc_m = M_PAT;
                    enc_hc = HC_PAT;
                    cm_phase = 3;
                end
            end
        end
    end

    task automatic push_pix(input logic [7:0] v);
        int w = 0;
        pix_valid = 1'b1;
        pix_data = v;
        while (!pix_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w == 20) chk("pix_ready_wait", 64'(pix_ready), 64'(1));
        if (v >= 8'd1 && v <= 8'd6) exp_pix.push_back(v);
        @(posedge clk); #1;
    endtask

    task automatic stream(input bit bad_en);
        for (int i = 0; i < 100; i++) begin
            if (bad_en && i == 30) push_pix(8'd0);
            if (bad_en && i == 60) push_pix(8'd7);
            push_pix(sym(i));
        end
        pix_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_res();
        exp_res.push_back({EXP_CNT, M_PAT, HC_PAT});
        res_target++;
    endtask

    task automatic wait_res();
        int n = 0;
        while (res_seen < res_target && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk("result_seen", 64'(res_seen >= res_target), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; res_ready = 1'b1;
        #1 reset = 1'b0;
        #5;
        chk("rst_enc_reset", 64'(enc_reset), 64'(1));
        chk("rst_flags", 64'({busy, pix_ready, enc_gray_valid, res_valid, err_bad_pix, err_timeout}),
            64'(0));
        chk("rst_gray_data", 64'(enc_gray_data), 64'(0));
        chk("rst_res_cnt", 64'(res_cnt), 64'(0));
        chk("rst_res_m", 64'(res_m), 64'(0));
        chk("rst_res_hc", 64'(res_hc), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("enc_reset_release", 64'(enc_reset), 64'(0));
        @(posedge clk); #1;

        // Frame A: start timing and clean stream.
        push_res();
        strobes = 0;
        pulse_start();
        @(negedge clk);
        chk("rearm_c1_enc_reset", 64'(enc_reset), 64'(1));
        chk("rearm_c1_busy", 64'(busy), 64'(1));
        chk("rearm_c1_pix_ready", 64'(pix_ready), 64'(0));
        @(negedge clk);
        chk("rearm_c2_enc_reset", 64'(enc_reset), 64'(1));
        chk("rearm_c2_pix_ready", 64'(pix_ready), 64'(0));
        @(negedge clk);
        chk("rearm_end_enc_reset", 64'(enc_reset), 64'(0));
        chk("pix_ready_first", 64'(pix_ready), 64'(1));
        @(posedge clk); #1;
        stream(1'b0);
        @(negedge clk);
        chk("pix_ready_drop", 64'(pix_ready), 64'(0));
        wait_res();
        chk("a_strobes", 64'(strobes), 64'(100));
        chk("a_err_bad_pix", 64'(err_bad_pix), 64'(0));

        // Frame B: illegal symbols mid-stream.
        push_res();
        strobes = 0;
        pulse_start();
        stream(1'b1);
        wait_res();
        chk("b_err_bad_pix", 64'(err_bad_pix), 64'(1));
        chk("b_strobes", 64'(strobes), 64'(100));

        // Frame C: slow core.
        strobes = 0;
        core_delay = 300;
`ifndef HUF_SCHED_WDOG_EN
        push_res();
`endif
        pulse_start();
        @(negedge clk);
        chk("start_clears_bad", 64'(err_bad_pix), 64'(0));
        @(posedge clk); #1;
        stream(1'b0);
`ifdef HUF_SCHED_WDOG_EN
        n = 0;
        while (!err_timeout && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_cycles", 64'(n), 64'(WDOG + 1));
        chk("wdog_err_timeout", 64'(err_timeout), 64'(1));
        chk("wdog_busy", 64'(busy), 64'(0));
        chk("wdog_res_valid", 64'(res_valid), 64'(0));
        repeat (80) @(negedge clk);
        chk("wdog_no_capture", 64'(res_seen), 64'(res_target));
        chk("wdog_res_valid_late", 64'(res_valid), 64'(0));
        @(posedge clk); #1;
`else
        wait_res();
        chk("nowdog_err_timeout", 64'(err_timeout), 64'(0));
`endif
        core_delay = 0;
        chk("c_strobes", 64'(strobes), 64'(100));

        // Frame D: consumer stalls in HOLD, start ignored until the handshake.
        res_ready = 1'b0;
        push_res();
        strobes = 0;
        pulse_start();
        stream(1'b0);
        n = 0;
        while (!res_valid && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", 64'(res_valid), 64'(1));
        @(posedge clk); #1;
        start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("hold_res_valid", 64'(res_valid), 64'(1));
            chk("hold_res_cnt", 64'(res_cnt), 64'(EXP_CNT));
            chk("hold_res_m", 64'(res_m), 64'(M_PAT));
            chk("hold_res_hc", 64'(res_hc), 64'(HC_PAT));
            chk("hold_busy", 64'(busy), 64'(1));
            chk("hold_no_rearm", 64'(enc_reset), 64'(0));
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("rearm_after_hold", 64'(enc_reset), 64'(1));
        chk("res_valid_after_hold", 64'(res_valid), 64'(0));
        chk("hold_result_taken", 64'(res_seen), 64'(res_target));
        chk("d_strobes", 64'(strobes), 64'(100));
        @(posedge clk); #1;

        // Frame E: reset during FEED after 40 symbols.
        strobes = 0;
        for (int i = 0; i < 40; i++) push_pix(sym(i));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_enc_reset", 64'(enc_reset), 64'(1));
        chk("midrst_flags", 64'({busy, pix_ready, enc_gray_valid, res_valid, err_bad_pix}), 64'(0));
        chk("midrst_gray_data", 64'(enc_gray_data), 64'(0));
        chk("midrst_strobes", 64'(strobes), 64'(40));
        chk("midrst_pix_queue", 64'(exp_pix.size()), 64'(0));
        pix_valid = 1'b0;
        exp_pix.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Frame F: full frame after the aborted one.
        push_res();
        strobes = 0;
        pulse_start();
        stream(1'b0);
        wait_res();
        chk("f_strobes", 64'(strobes), 64'(100));

        chk("end_pix_queue", 64'(exp_pix.size()), 64'(0));
        chk("end_res_queue", 64'(exp_res.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/huffman_frame_sched.md
# huffman_frame_sched

Frame scheduler for the six-symbol Huffman encoder core. It re-arms the core with a reset pulse and streams one frame of gray pixels from a valid/ready source into the core's gray_valid/gray_data input. It then captures the CNT, M and HC results and presents them to a downstream consumer over a valid/ready handshake. It sits between the pixel buffer and the encoder and is the only block that drives the encoder's reset and pixel inputs.

## Interface
- FRAME_LEN, 100: accepted symbols per frame; 1..255; must equal the core's completion total.
- REARM_CYCLES, 2: cycles enc_reset is held high per frame; 1..15.
- WDOG_CYCLES, 255: result-wait limit in cycles; 1..65535.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE and on the HOLD release cycle.
- busy  out  1  high in every state except IDLE.
- pix_valid  in  1  source pixel valid.
- pix_data  in  8  source pixel value.
- pix_ready  out  1  high only in FEED.
- enc_reset  out  1  active-high reset to the encoder core.
- enc_gray_valid  out  1  registered pixel strobe to the core.
- enc_gray_data  out  8  registered pixel value to the core.
- enc_cnt_valid  in  1  core CNT_valid.
- enc_code_valid  in  1  core code_valid.
- enc_cnt  in  48  packed {CNT6..CNT1}.
- enc_m  in  48  packed {M6..M1}.
- enc_hc  in  48  packed {HC6..HC1}.
- res_valid  out  1  captured frame result valid.
- res_ready  in  1  consumer accept.
- res_cnt, res_m, res_hc  out  48 each  captured results, same packing as the enc_ inputs.
- err_bad_pix  out  1  sticky: a pixel outside 1..6 was dropped.
- err_timeout  out  1  sticky: watchdog expired.

## Operation
- States: IDLE, REARM, FEED, WAIT_CNT, WAIT_CODE, HOLD.
- IDLE: outputs quiet. start=1 clears both error flags and res_valid, then goes to REARM.
- REARM: enc_reset=1 for exactly REARM_CYCLES cycles. The feed counter and watchdog are cleared. Then FEED.
- FEED: a transfer occurs on pix_valid & pix_ready.
  - pix_data in 1..6: next cycle enc_gray_valid=1 and enc_gray_data=pix_data; feed_cnt increments (8-bit).
  - pix_data outside 1..6: dropped, not counted, err_bad_pix set. enc_gray_valid stays 0.
  - The transfer that makes feed_cnt reach FRAME_LEN moves the FSM to WAIT_CNT. pix_ready drops in the next cycle.
- WAIT_CNT: on enc_cnt_valid, capture enc_cnt into res_cnt, then WAIT_CODE.
- WAIT_CODE: on enc_code_valid, capture enc_m and enc_hc, then HOLD.
- HOLD: res_valid=1 and the res_* buses stay stable until res_ready. On the handshake cycle, go to REARM if start=1, otherwise IDLE.
- enc_cnt_valid and enc_code_valid outside their wait state are ignored.
- The watchdog is a 16-bit counter running in WAIT_CNT and WAIT_CODE only. On reaching WDOG_CYCLES it sets err_timeout and returns to IDLE. res_valid stays 0 and no capture occurs.
- start asserted in REARM, FEED, WAIT_* or HOLD (before the handshake) is ignored.

## Timing
- Reset values: state IDLE; enc_reset=1 during reset and 0 from the first clock after release. All other outputs and res_* are 0.
- start sampled at edge N: enc_reset is high for cycles N+1..N+REARM_CYCLES. pix_ready is first high at cycle N+REARM_CYCLES+1.
- Pixel path latency: one cycle from accepted transfer to enc_gray_valid. Throughput is one symbol per cycle.
- Capture: res_cnt is valid the cycle after enc_cnt_valid. res_valid rises the cycle after enc_code_valid.
- Reset asserted mid-frame: immediate return to IDLE, enc_reset=1, and the partial frame is discarded.

## Configuration
- HUF_SCHED_WDOG_EN defined: watchdog and err_timeout behave as described above.
- Undefined: no watchdog logic. err_timeout is tied to 0, and the FSM waits indefinitely in WAIT_CNT and WAIT_CODE.

## Test plan
- Reset release then start: enc_reset high exactly 2 cycles, pix_ready first high at N+3, busy=1 from N+1.
- Stream 100 symbols (20×1, 20×2, 15×3, 15×4, 15×5, 15×6) with pix_valid always 1: exactly 100 enc_gray_valid pulses, pix_ready low afterwards, res_cnt = {15,15,15,15,20,20} in {CNT6..CNT1} order.
- Inject values 0 and 7 mid-stream: both dropped, err_bad_pix=1, still exactly 100 strobes. A subsequent start clears err_bad_pix.
- Core model delays CNT_valid by 300 cycles (watchdog on): err_timeout=1 at 255 wait cycles, state IDLE, res_valid=0. With the macro off: result captured normally.
- Hold res_ready=0 for 10 cycles in HOLD: res_* stable, start ignored. Then res_ready=1 with start=1: enc_reset pulses next cycle.
- Reset asserted during FEED after 40 symbols: outputs return to reset values at once. The next frame counts from 0.
